// File: rtl/snl_pkg.sv
// Shared types and constants for the N-player snakes-and-ladders engine:
// FSM states, the LFSR feedback taps and the default 100-square jump table.
package snl_pkg;

  typedef enum logic [2:0] {
    S_ROLL,
    S_MOVE,
    S_JUMP,
    S_NEXT,
    S_DONE
  } state_e;

  // Fibonacci taps for x^16+x^14+x^13+x^11+1 (bits 15,13,12,10)
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam int NUM_JUMPS = 16;
  // First eight entries are ladders, last eight are snakes
  localparam int JUMP_SRC [NUM_JUMPS] = '{4, 9, 20, 28, 40, 51, 63, 71,
                                          17, 54, 62, 64, 87, 93, 95, 99};
  localparam int JUMP_DST [NUM_JUMPS] = '{14, 31, 38, 84, 59, 67, 81, 91,
                                          7, 34, 19, 60, 24, 73, 75, 78};

endpackage

// File: rtl/snl_jump_map.sv
// Combinational square remap: returns the ladder/snake destination for pos_in,
// or pos_in itself when the square has no entry on this board size.
module snl_jump_map
  import snl_pkg::*;
#(
  parameter int BOARD_SIZE = 100,
  parameter int POS_W      = 7
) (
  input  logic [POS_W-1:0] pos_in,
  output logic [POS_W-1:0] pos_out
);

  always_comb begin
    pos_out = pos_in;
    for (int i = 0; i < NUM_JUMPS; i++) begin
      // Entries that fall off a smaller board are treated as absent
      if (JUMP_SRC[i] < BOARD_SIZE && JUMP_DST[i] < BOARD_SIZE &&
          int'(pos_in) == JUMP_SRC[i]) begin
        pos_out = POS_W'(JUMP_DST[i]);
      end
    end
  end

endmodule

// File: rtl/snakes_ladders_np.sv
// N-player snakes-and-ladders engine: LFSR dice with rejection sampling,
// four-state turn sequence (roll, move, jump, next) and a terminal done state.
module snakes_ladders_np
  import snl_pkg::*;
#(
  parameter int          NUM_PLAYERS  = 4,
  parameter int          BOARD_SIZE   = 100,
  parameter int          POS_W        = 7,
  parameter int          EXACT_FINISH = 1,
  parameter int          SIX_REROLL   = 1,
  parameter int          MAX_TURNS    = 1000,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             roll_en,
  input  logic                             dice_force_en,
  input  logic [2:0]                       dice_force_val,
  output logic [NUM_PLAYERS*POS_W-1:0]     pos_flat,
  output logic [$clog2(NUM_PLAYERS)-1:0]   cur_player,
  output logic [2:0]                       dice,
  output logic [15:0]                      turn_cnt,
  output logic                             game_over,
  output logic                             winner_valid,
  output logic [$clog2(NUM_PLAYERS)-1:0]   winner_id
);

  localparam int          PID_W       = $clog2(NUM_PLAYERS);
  localparam logic [15:0] SEED        = (LFSR_SEED == 16'd0) ? 16'd1 : LFSR_SEED;
  localparam logic [POS_W-1:0] BOARD_POS   = POS_W'(BOARD_SIZE);
  localparam logic [PID_W-1:0] LAST_PLAYER = PID_W'(NUM_PLAYERS - 1);

  state_e            state_q, state_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic [POS_W-1:0]  pos_q [NUM_PLAYERS];
  logic [POS_W-1:0]  pos_d [NUM_PLAYERS];
  logic [PID_W-1:0]  cur_q, cur_d;
  logic [2:0]        dice_q, dice_d;
  logic [15:0]       turn_q, turn_d;
  logic              over_q, over_d;
  logic              win_q, win_d;
  logic [PID_W-1:0]  wid_q, wid_d;

  logic [POS_W-1:0]  cur_pos;
  logic [POS_W-1:0]  jump_pos;
  logic [POS_W:0]    sum;
  logic [2:0]        force_val;

  assign cur_pos = pos_q[cur_q];

  snl_jump_map #(
    .BOARD_SIZE (BOARD_SIZE),
    .POS_W      (POS_W)
  ) u_jump_map (
    .pos_in  (cur_pos),
    .pos_out (jump_pos)
  );

  always_comb begin
    lfsr_d    = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
    state_d   = state_q;
    pos_d     = pos_q;
    cur_d     = cur_q;
    dice_d    = dice_q;
    turn_d    = turn_q;
    over_d    = over_q;
    win_d     = win_q;
    wid_d     = wid_q;
    force_val = (dice_force_val == 3'd0 || dice_force_val == 3'd7) ? 3'd1 : dice_force_val;
    // One extra bit so an overshoot past the last square is visible
    sum       = {1'b0, cur_pos} + (POS_W + 1)'(dice_q);

    case (state_q)
      S_ROLL: begin
        if (roll_en) begin
          if (dice_force_en) begin
            dice_d  = force_val;
            state_d = S_MOVE;
          end else if (lfsr_q[2:0] != 3'd0 && lfsr_q[2:0] != 3'd7) begin
            dice_d  = lfsr_q[2:0];
            state_d = S_MOVE;
          end
        end
      end
      S_MOVE: begin
        if (sum > (POS_W + 1)'(BOARD_SIZE)) begin
          if (EXACT_FINISH == 0) pos_d[cur_q] = BOARD_POS;
        end else begin
          pos_d[cur_q] = sum[POS_W-1:0];
        end
        state_d = S_JUMP;
      end
      S_JUMP: begin
        if (cur_pos == BOARD_POS) begin
          over_d  = 1'b1;
          win_d   = 1'b1;
          wid_d   = cur_q;
          state_d = S_DONE;
        end else begin
          pos_d[cur_q] = jump_pos;
          state_d      = S_NEXT;
        end
      end
      S_NEXT: begin
        turn_d = (turn_q == 16'hFFFF) ? turn_q : turn_q + 16'd1;
        if (!(SIX_REROLL != 0 && dice_q == 3'd6)) begin
          cur_d = (cur_q == LAST_PLAYER) ? '0 : cur_q + 1'b1;
        end
        if (MAX_TURNS != 0 && turn_d == 16'(MAX_TURNS)) begin
          over_d  = 1'b1;
          win_d   = 1'b0;
          state_d = S_DONE;
        end else begin
          state_d = S_ROLL;
        end
      end
      S_DONE: state_d = S_DONE;
      default: state_d = S_ROLL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_ROLL;
      lfsr_q  <= SEED;
      for (int i = 0; i < NUM_PLAYERS; i++) pos_q[i] <= '0;
      cur_q   <= '0;
      dice_q  <= '0;
      turn_q  <= '0;
      over_q  <= 1'b0;
      win_q   <= 1'b0;
      wid_q   <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      pos_q   <= pos_d;
      cur_q   <= cur_d;
      dice_q  <= dice_d;
      turn_q  <= turn_d;
      over_q  <= over_d;
      win_q   <= win_d;
      wid_q   <= wid_d;
    end
  end

  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_pos
    assign pos_flat[g*POS_W +: POS_W] = pos_q[g];
  end

  assign cur_player   = cur_q;
  assign dice         = dice_q;
  assign turn_cnt     = turn_q;
  assign game_over    = over_q;
  assign winner_valid = win_q;
  assign winner_id    = wid_q;

endmodule
